axi_pchase_multi: RTL and testbench

Multi-chain AXI4 pointer-chase latency benchmark engine.
- Runs NUM_CHAIN independent linked-list walks concurrently over one AXI4 read port.
- Each chain has at most one burst outstanding; the next address comes from the first beat of the previous response.
- Reports total clock cycles and response errors through an ap_start/ap_ready/ap_done/ap_idle control interface.
- Generalised successor of the single-chain pointer-chase engine: parametrised widths, chain count, burst length; adds error reporting.

---
 rtl/axi_pchase_multi_pkg.sv | 13 +
 rtl/axi_pchase_multi_if.sv | 24 ++
 rtl/axi_pchase_multi_rr_arb.sv | 31 +++
 rtl/axi_pchase_multi.sv | 157 +++++++++++++++
 tb/tb_axi_pchase_multi.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pchase_multi_pkg.sv
// axi_pchase_pkg: shared AXI constants, state encodings and helpers for the pointer-chase engine
package axi_pchase_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    typedef enum logic [1:0] {IDLE, RUN, DONE} top_state_e;
    typedef enum logic [1:0] {PEND, OUT, FIN} chain_state_e;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/axi_pchase_multi_if.sv
// axi_pchase_multi_if: AXI4 read-address and read-data channels of the pointer-chase engine
interface axi_pchase_multi_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int ID_W   = 2
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic              rlast;
    modport master(output arvalid, araddr, arid, arlen, arsize, arburst, rready,
                   input arready, rvalid, rdata, rid, rresp, rlast);
    modport slave(input arvalid, araddr, arid, arlen, arsize, arburst, rready,
                  output arready, rvalid, rdata, rid, rresp, rlast);
endinterface

// File: rtl/axi_pchase_multi_rr_arb.sv
// pchase_rr_arb: round-robin arbiter; priority rotates past the last winner on each advance
module pchase_rr_arb import axi_pchase_pkg::*; #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);
    logic [IW-1:0] last_q;
    // scan downwards so the requester closest after the last winner is chosen
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[(int'(last_q) + 1 + i) % N]) begin
                gnt_o = '0;
                gnt_o[(int'(last_q) + 1 + i) % N] = 1'b1;
                idx_o = IW'((int'(last_q) + 1 + i) % N);
            end
        end
    end
    // remember the winner once its grant is consumed
    always_ff @(posedge clk) begin
        if (reset) last_q <= IW'(N - 1);
        else if (adv_i && |req_i) last_q <= idx_o;
    end
endmodule

// File: rtl/axi_pchase_multi.sv
// axi_pchase_multi: multi-chain AXI4 pointer-chase latency engine with ap_* control
module axi_pchase_multi import axi_pchase_pkg::*; #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 512,
    parameter int NUM_CHAIN = 4,
    parameter int ID_W      = 2,
    parameter int BURST_LEN = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    axi_pchase_multi_if.master          axi,
    input  logic [NUM_CHAIN*ADDR_W-1:0] start_addr,
    input  logic [31:0]                 num_burst,
    output logic [31:0]                 cnt_clk,
    output logic                        err,
    output logic [NUM_CHAIN-1:0]        chain_done,
    input  logic                        ap_start,
    output logic                        ap_ready,
    output logic                        ap_done,
    output logic                        ap_idle
);
    localparam int OFF_W = clog2(DATA_W / 8);
    localparam int CW = (NUM_CHAIN > 1) ? clog2(NUM_CHAIN) : 1;
    localparam logic [ADDR_W-1:0] ALIGN = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    top_state_e state_q;
    chain_state_e cst_q [NUM_CHAIN];
    logic [ADDR_W-1:0] ptr_q [NUM_CHAIN];
    logic [ADDR_W-1:0] ptr_d [NUM_CHAIN];
    logic [31:0] bcnt_q [NUM_CHAIN];
    logic [NUM_CHAIN-1:0] first_q, done_q, hit, to_pend, req, gnt, fin;
    logic [31:0] nb_q, cnt_q;
    logic arvalid_q, rready_q, err_q, ap_ready_q, ap_done_q, ap_idle_q, beat, load;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [ID_W-1:0] arid_q;
    logic [CW-1:0] idx;
    logic unused_rdata;
    assign unused_rdata = ^axi.rdata[DATA_W-1:ADDR_W];
    assign beat = axi.rvalid && rready_q;
    assign load = !arvalid_q && |req;
    // decode the R beat per chain; a chain finishing a burst may request in the same cycle
    always_comb begin
        araddr_d = '0;
        for (int c = 0; c < NUM_CHAIN; c++) begin
            hit[c] = beat && int'(axi.rid) == c && cst_q[c] == OUT;
            ptr_d[c] = (hit[c] && first_q[c]) ? axi.rdata[ADDR_W-1:0] : ptr_q[c];
            to_pend[c] = hit[c] && axi.rlast && bcnt_q[c] + 32'd1 != nb_q;
            req[c] = state_q == RUN && (cst_q[c] == PEND || to_pend[c]);
            fin[c] = cst_q[c] == FIN;
            araddr_d = araddr_d | (gnt[c] ? (ptr_d[c] & ALIGN) : '0);
        end
    end
    pchase_rr_arb #(.N(NUM_CHAIN)) u_arb (
        .clk(clk), .reset(reset), .req_i(req), .adv_i(load), .gnt_o(gnt), .idx_o(idx)
    );
    // top control FSM with registered handshake, cycle counter and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rready_q <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
            nb_q <= '0;
            ap_ready_q <= 1'b0;
            ap_done_q <= 1'b0;
            ap_idle_q <= 1'b1;
        end else begin
            ap_ready_q <= 1'b0;
            case (state_q)
                IDLE: if (ap_start) begin
                    nb_q <= num_burst;
                    cnt_q <= '0;
                    err_q <= 1'b0;
                    ap_ready_q <= 1'b1;
                    ap_idle_q <= 1'b0;
                    ap_done_q <= num_burst == '0;
                    rready_q <= num_burst != '0;
                    state_q <= (num_burst == '0) ? DONE : RUN;
                end
                RUN: begin
                    cnt_q <= cnt_q + {31'd0, ~&cnt_q};
                    if (beat && (!(|hit) || axi.rresp != AXI_RESP_OKAY)) err_q <= 1'b1;
                    if (&fin) begin
                        state_q <= DONE;
                        ap_done_q <= 1'b1;
                        rready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ap_done_q <= 1'b0;
                    ap_idle_q <= 1'b1;
                end
            endcase
        end
    end
    // per-chain walk: pointer capture on the first beat, burst counting, completion
    always_ff @(posedge clk) begin
        if (reset) begin
            first_q <= '0;
            done_q <= '0;
            for (int c = 0; c < NUM_CHAIN; c++) begin
                cst_q[c] <= PEND;
                ptr_q[c] <= '0;
                bcnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHAIN; c++) begin
                if (state_q == IDLE && ap_start) begin
                    cst_q[c] <= PEND;
                    ptr_q[c] <= start_addr[c*ADDR_W +: ADDR_W];
                    bcnt_q[c] <= '0;
                    first_q[c] <= 1'b0;
                    done_q[c] <= 1'b0;
                end else begin
                    ptr_q[c] <= ptr_d[c];
                    if (hit[c]) first_q[c] <= 1'b0;
                    if (arvalid_q && axi.arready && int'(arid_q) == c) begin
                        cst_q[c] <= OUT;
                        first_q[c] <= 1'b1;
                    end
                    if (hit[c] && axi.rlast) begin
                        bcnt_q[c] <= bcnt_q[c] + 32'd1;
                        cst_q[c] <= to_pend[c] ? PEND : FIN;
                        done_q[c] <= !to_pend[c];
                    end
                end
            end
        end
    end
    // AR channel: hold the registered grant until accepted, reload on the following cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            arvalid_q <= 1'b0;
            araddr_q <= '0;
            arid_q <= '0;
        end else if (arvalid_q) begin
            arvalid_q <= !axi.arready;
        end else if (load) begin
            arvalid_q <= 1'b1;
            araddr_q <= araddr_d;
            arid_q <= ID_W'(idx);
        end
    end
    assign axi.arvalid = arvalid_q;
    assign axi.araddr = araddr_q;
    assign axi.arid = arid_q;
    assign axi.arlen = 8'(BURST_LEN - 1);
    assign axi.arsize = 3'(OFF_W);
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.rready = rready_q;
    assign cnt_clk = cnt_q;
    assign err = err_q;
    assign chain_done = done_q;
    assign ap_ready = ap_ready_q;
    assign ap_done = ap_done_q;
    assign ap_idle = ap_idle_q;
endmodule

// File: tb/tb_axi_pchase_multi.sv
// tb_axi_pchase_multi: table-driven runs against an out-of-order AXI slave with an AR scoreboard
module tb_axi_pchase_multi;
    localparam int AW = 64, DW = 512, NC = 4, IW = 3, BL = 4;
    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
    } ar_t;
    typedef struct packed {
        logic [NC*AW-1:0] heads;
        logic [31:0]      nb;
        logic             stall;
        logic             inj;
        logic             exp_err;
        logic [NC-1:0]    exp_done;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    axi_pchase_multi_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bif();
    logic [NC*AW-1:0] start_addr;
    logic [31:0] num_burst, cnt_clk;
    logic err, ap_start, ap_ready, ap_done, ap_idle;
    logic [NC-1:0] chain_done;
    axi_pchase_multi #(.ADDR_W(AW), .DATA_W(DW), .NUM_CHAIN(NC), .ID_W(IW), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset), .axi(bif), .start_addr(start_addr), .num_burst(num_burst),
        .cnt_clk(cnt_clk), .err(err), .chain_done(chain_done), .ap_start(ap_start),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle)
    );
    ar_t exp_q[$];
    ar_t pend[$];
    ar_t cur;
    vec_t tbl[6];
    int errors = 0, checks = 0;
    int stall_cnt = 0, beat = 0, run_ar = 0, rr_next = 0;
    bit stall_req = 0, inj_resp = 0, inj_rid = 0, cur_act = 0;
    logic [AW-1:0] s_addr;
    logic [IW-1:0] s_id;
    logic [NC-1:0] out_mask = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [NC*AW-1:0] heads, input logic [31:0] nb);
        for (int c = 0; c < NC; c++) begin
            logic [63:0] a;
            a = heads[c*AW +: AW] & ~64'h3F;
            for (int b = 0; b < int'(nb); b++) begin
                exp_q.push_back('{id: IW'(c), addr: a});
                a = a + 64'h1040;
            end
        end
    endtask

    task automatic ar_accept();
        int k;
        k = -1;
        chk("arlen", 64'(bif.arlen), 64'd3);
        chk("arsize", 64'(bif.arsize), 64'd6);
        chk("arburst", 64'(bif.arburst), 64'd1);
        if (run_ar < NC) chk("rr_order", 64'(bif.arid), 64'(rr_next));
        run_ar++;
        rr_next = (int'(bif.arid) + 1) % NC;
        chk("arid_range", 64'(int'(bif.arid) < NC), 64'd1);
        if (int'(bif.arid) < NC) chk("ar_only_pend", 64'(out_mask[bif.arid[1:0]]), 64'd0);
        foreach (exp_q[i]) if (k < 0 && exp_q[i].id == bif.arid) k = i;
        chk("ar_expected", 64'(k >= 0), 64'd1);
        if (k >= 0) begin
            chk("araddr", bif.araddr, exp_q[k].addr);
            exp_q.delete(k);
        end
        pend.push_back('{id: bif.arid, addr: bif.araddr});
        out_mask[bif.arid[1:0]] = 1'b1;
    endtask

    task automatic slave_r();
        bif.rvalid = 1'b0;
        bif.rlast = 1'b0;
        bif.rresp = 2'b00;
        if (!cur_act && inj_rid && bif.rready) begin
            bif.rvalid = 1'b1;
            bif.rid = 3'd7;
            bif.rlast = 1'b1;
            bif.rdata = {16{32'h5A5A_0001}};
            inj_rid = 0;
            return;
        end
        if (!cur_act && pend.size() > 0 && $urandom_range(0, 1) == 1) begin
            int i;
            i = $urandom_range(0, pend.size() - 1);
            cur = pend[i];
            pend.delete(i);
            cur_act = 1;
            beat = 0;
        end
        if (cur_act) begin
            bif.rvalid = 1'b1;
            bif.rid = cur.id;
            bif.rlast = beat == BL - 1;
            bif.rdata = {{7{cur.addr ^ 64'hA5A5}}, (beat == 0) ? cur.addr + 64'h1055 : 64'hDEAD};
            if (inj_resp) bif.rresp = 2'b10;
            if (bif.rready) begin
                inj_resp = 0;
                beat++;
                if (beat == BL) begin
                    cur_act = 0;
                    out_mask[cur.id[1:0]] = 1'b0;
                end
            end
        end
    endtask

    task automatic slave_ar();
        if (stall_cnt > 0) begin
            chk("ar_hold_addr", bif.araddr, s_addr);
            chk("ar_hold_id", 64'(bif.arid), 64'(s_id));
            chk("ar_hold_valid", 64'(bif.arvalid), 64'd1);
            stall_cnt--;
            bif.arready = stall_cnt == 0;
        end else if (stall_req && bif.arvalid) begin
            s_addr = bif.araddr;
            s_id = bif.arid;
            stall_req = 0;
            stall_cnt = 5;
            bif.arready = 1'b0;
        end else begin
            bif.arready = $urandom_range(0, 2) != 0;
        end
        if (bif.arvalid && bif.arready) ar_accept();
    endtask

    // slave: all inputs decided just after each rising edge for the next one
    initial begin
        bif.arready = 1'b0;
        bif.rvalid = 1'b0;
        bif.rdata = '0;
        bif.rid = '0;
        bif.rresp = 2'b00;
        bif.rlast = 1'b0;
        forever begin
            tick();
            if (reset) begin
                pend.delete();
                cur_act = 0;
                out_mask = '0;
                stall_cnt = 0;
                bif.arready = 1'b0;
                bif.rvalid = 1'b0;
            end else begin
                slave_r();
                slave_ar();
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_arvalid"}, 64'(bif.arvalid), 64'd0);
        chk({tag, "_rready"}, 64'(bif.rready), 64'd0);
        chk({tag, "_cnt_clk"}, 64'(cnt_clk), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_chain_done"}, 64'(chain_done), 64'd0);
        chk({tag, "_ap_ready"}, 64'(ap_ready), 64'd0);
        chk({tag, "_ap_done"}, 64'(ap_done), 64'd0);
        chk({tag, "_ap_idle"}, 64'(ap_idle), 64'd1);
    endtask

    task automatic do_run(input vec_t v);
        int k;
        k = 0;
        push_exp(v.heads, v.nb);
        stall_req = v.stall;
        inj_resp = v.inj;
        inj_rid = v.inj;
        run_ar = 0;
        start_addr = v.heads;
        num_burst = v.nb;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        chk("ap_ready", 64'(ap_ready), 64'd1);
        chk("ap_idle_run", 64'(ap_idle), 64'd0);
        while (!ap_done && k < 3000) begin
            k++;
            tick();
        end
        chk("ap_done_seen", 64'(ap_done), 64'd1);
        chk("cnt_clk", 64'(cnt_clk), 64'(k));
        chk("err", 64'(err), 64'(v.exp_err));
        chk("chain_done", 64'(chain_done), 64'(v.exp_done));
        chk("ar_remaining", 64'(exp_q.size()), 64'd0);
        tick();
        chk("ap_done_pulse", 64'(ap_done), 64'd0);
        chk("ap_ready_pulse", 64'(ap_ready), 64'd0);
        chk("ap_idle_back", 64'(ap_idle), 64'd1);
        chk("err_hold", 64'(err), 64'(v.exp_err));
        chk("cnt_hold", 64'(cnt_clk), 64'(k));
        chk("done_hold", 64'(chain_done), 64'(v.exp_done));
        chk("arvalid_idle", 64'(bif.arvalid), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        tbl[0] = '{heads: {64'h4000, 64'h3000, 64'h2000, 64'h1000}, nb: 2, stall: 0, inj: 0, exp_err: 0, exp_done: 4'hF};
        tbl[1] = '{heads: {64'h70000, 64'h60000, 64'h50000, 64'h1000}, nb: 3, stall: 0, inj: 0, exp_err: 0, exp_done: 4'hF};
        tbl[2] = '{heads: {64'h8C0, 64'h880, 64'h840, 64'h800}, nb: 1, stall: 1, inj: 0, exp_err: 0, exp_done: 4'hF};
        tbl[3] = '{heads: {64'h24000, 64'h23000, 64'h22000, 64'h21000}, nb: 2, stall: 0, inj: 1, exp_err: 1, exp_done: 4'hF};
        tbl[4] = '{heads: {64'h1, 64'h2, 64'h3, 64'h4}, nb: 0, stall: 0, inj: 0, exp_err: 0, exp_done: 4'h0};
        tbl[5] = '{heads: {64'h40039, 64'h30011, 64'h2003F, 64'h10007}, nb: 2, stall: 0, inj: 0, exp_err: 0, exp_done: 4'hF};
        ap_start = 1'b0;
        start_addr = '0;
        num_burst = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_reset("rst");
        for (int i = 0; i < 6; i++) do_run(tbl[i]);
        push_exp(tbl[0].heads, 32'd8);
        run_ar = 0;
        start_addr = tbl[0].heads;
        num_burst = 32'd8;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        repeat (15) tick();
        chk("midrun_busy", 64'(ap_idle), 64'd0);
        reset = 1'b1;
        tick();
        chk_reset("midrst");
        exp_q.delete();
        rr_next = 0;
        tick();
        reset = 1'b0;
        tick();
        do_run(tbl[0]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
